// File: rtl/dsp_mac_seq_pkg.sv
// Shared types and constants for the dot-product sequencer around the DSP48A1 slice.
package dsp_mac_pkg;

  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;

  typedef enum logic [0:0] {
    S_FIRST = 1'b0,
    S_ACC   = 1'b1
  } mac_state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } beat_tag_t;

endpackage

// File: rtl/dsp_mac_seq_if.sv
// Stream-side bundle: (a,b) beats in, one accumulated result per vector out.
interface dsp_mac_seq_if #(
  parameter int LEN_W = 16
);
  logic               s_valid;
  logic               s_ready;
  logic signed [17:0] s_a;
  logic signed [17:0] s_b;
  logic               s_last;
  logic               m_valid;
  logic               m_ready;
  logic [47:0]        m_data;
  logic [LEN_W-1:0]   m_len;
  logic               m_ovf;

  modport master (
    output s_valid, s_a, s_b, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_len, m_ovf
  );

  modport slave (
    input  s_valid, s_a, s_b, s_last, m_ready,
    output s_ready, m_valid, m_data, m_len, m_ovf
  );
endinterface

// File: rtl/dsp_mac_seq_out_fifo.sv
// Two-entry result FIFO; head entry is always visible, push and pop may share an edge.
module mac_out_fifo #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dsp_mac_seq.sv
// Drives a DSP48A1 slice to accumulate sum(a*b) per vector and queues one result per vector.
module dsp_mac_seq
  import dsp_mac_pkg::*;
#(
  parameter int DSP_LAT = 3,
  parameter int LEN_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  dsp_mac_seq_if.slave bus,
  output logic [17:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [7:0]  dsp_opmode,
  output logic        dsp_cep,
  output logic        dsp_rstp,
  input  logic [47:0] dsp_p,
  input  logic        dsp_carryout
);

  localparam logic [0:0] ST_FIRST = S_FIRST;
  localparam logic [0:0] ST_ACC   = S_ACC;
  localparam int         FW       = 48 + LEN_W + 1;

  logic [0:0]              state;
  beat_tag_t [DSP_LAT:0]   taps;
  beat_tag_t               new_tag;
  beat_tag_t               p_tag;
  logic                    accept;
  logic                    s_ready;
  logic [2:0]              lasts_in_flight;
  logic [2:0]              busy;
  logic [1:0]              fifo_count;
  logic [FW-1:0]           fifo_head;
  logic [LEN_W-1:0]        len_cnt;
  logic [LEN_W-1:0]        len_next;
  logic                    ovf_acc;
  logic                    ovf_next;
  logic                    push;
  logic                    pop;

  // A result slot is reserved as soon as a last beat enters the pipe, so pushes never see a full FIFO.
  always_comb begin
    lasts_in_flight = 3'd0;
    for (int k = 0; k <= DSP_LAT; k++) begin
      if (taps[k].valid && taps[k].last) begin
        lasts_in_flight = lasts_in_flight + 3'd1;
      end
    end
  end

  assign busy        = {1'b0, fifo_count} + lasts_in_flight;
  assign s_ready     = (busy < 3'd2);
  assign bus.s_ready = s_ready;
  assign accept      = bus.s_valid && s_ready;

  always_comb begin
    new_tag       = '0;
    new_tag.valid = accept;
    new_tag.first = accept && (state == ST_FIRST);
    new_tag.last  = accept && bus.s_last;
  end

  assign p_tag    = taps[DSP_LAT];
  assign dsp_cep  = taps[DSP_LAT-1].valid;
  assign dsp_rstp = rst;

  // Length and overflow are tracked at the P stage so they stay aligned with the captured sum.
  always_comb begin
    if (p_tag.first) begin
      len_next = LEN_W'(1);
      ovf_next = 1'b0;
    end else begin
      len_next = (len_cnt == '1) ? len_cnt : len_cnt + LEN_W'(1);
      ovf_next = ovf_acc | dsp_carryout;
    end
  end

  assign push = p_tag.valid && p_tag.last;
  assign pop  = bus.m_valid && bus.m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FIRST;
      dsp_a      <= '0;
      dsp_b      <= '0;
      dsp_opmode <= '0;
      taps       <= '0;
      len_cnt    <= '0;
      ovf_acc    <= 1'b0;
    end else begin
      if (accept) begin
        dsp_a <= bus.s_a;
        dsp_b <= bus.s_b;
        if (state == ST_FIRST && !bus.s_last) begin
          state <= ST_ACC;
        end else if (state == ST_ACC && bus.s_last) begin
          state <= ST_FIRST;
        end
      end
      taps <= {taps[DSP_LAT-1:0], new_tag};
      if (taps[DSP_LAT-2].valid) begin
        dsp_opmode <= taps[DSP_LAT-2].first ? OPM_FIRST : OPM_ACC;
      end else begin
        dsp_opmode <= 8'h00;
      end
      if (p_tag.valid) begin
        len_cnt <= len_next;
        ovf_acc <= ovf_next;
      end
    end
  end

  mac_out_fifo #(
    .W(FW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({dsp_p, len_next, ovf_next}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign bus.m_valid = (fifo_count != 2'd0);
  assign bus.m_data  = fifo_head[FW-1 -: 48];
  assign bus.m_len   = fifo_head[LEN_W:1];
  assign bus.m_ovf   = fifo_head[0];

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Directed bench for dsp_mac_seq with a behavioural DSP48A1 (A1/B1, M, P registers) closing the loop.
module tb_dsp_mac_seq;

  logic        clk;
  logic        rst;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [7:0]  dsp_opmode;
  logic        dsp_cep;
  logic        dsp_rstp;
  logic [47:0] dsp_p;
  logic        dsp_carryout;

  int checks = 0;
  int errors = 0;

  dsp_mac_seq_if #(.LEN_W(16)) bus ();

  dsp_mac_seq #(
    .DSP_LAT(3),
    .LEN_W  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dsp_a       (dsp_a),
    .dsp_b       (dsp_b),
    .dsp_opmode  (dsp_opmode),
    .dsp_cep     (dsp_cep),
    .dsp_rstp    (dsp_rstp),
    .dsp_p       (dsp_p),
    .dsp_carryout(dsp_carryout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice model: A1/B1 register, M register, then P with Z=P or Z=0 selected by opmode[3:2].
  logic signed [17:0] a1;
  logic signed [17:0] b1;
  logic signed [35:0] mreg;
  logic [47:0]        mext;
  logic [48:0]        psum;

  always @(posedge clk) begin
    if (dsp_rstp) begin
      a1           <= '0;
      b1           <= '0;
      mreg         <= '0;
      dsp_p        <= '0;
      dsp_carryout <= 1'b0;
    end else begin
      a1   <= dsp_a;
      b1   <= dsp_b;
      mreg <= a1 * b1;
      if (dsp_cep) begin
        mext = {{12{mreg[35]}}, mreg};
        if (dsp_opmode[3:2] == 2'b10) psum = {1'b0, dsp_p} + {1'b0, mext};
        else psum = {1'b0, mext};
        dsp_p        <= psum[47:0];
        dsp_carryout <= psum[48];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [17:0] a, input logic [17:0] b, input logic last);
    int waited;
    waited      = 0;
    bus.s_valid = 1'b1;
    bus.s_a     = a;
    bus.s_b     = b;
    bus.s_last  = last;
    while (!bus.s_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!bus.s_ready) check("s_ready_timeout", bus.s_ready, 1);
    tick();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // Called just after the last beat's accept edge; expects m_valid exactly on E4 for one cycle.
  task automatic expect_result(input string tag, input logic [47:0] data,
                               input logic [15:0] len, input logic ovf);
    tick(); tick(); tick();
    check({tag, "_early"}, bus.m_valid, 0);
    tick();
    check({tag, "_valid"}, bus.m_valid, 1);
    check({tag, "_data"}, bus.m_data, data);
    check({tag, "_len"}, bus.m_len, len);
    check({tag, "_ovf"}, bus.m_ovf, ovf);
    tick();
    check({tag, "_one_cycle"}, bus.m_valid, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_a     = '0;
    bus.s_b     = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    tick();
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_m_len", bus.m_len, 0);
    check("rst_dsp_a", dsp_a, 0);
    check("rst_opmode", dsp_opmode, 0);
    check("rst_cep", dsp_cep, 0);
    rst = 1'b0;

    $display("[TB] single beat 10*20");
    send_beat(18'd10, 18'd20, 1'b1);
    check("single_dsp_a", dsp_a, 10);
    expect_result("single", 48'd200, 16'd1, 1'b0);

    $display("[TB] back-to-back vector");
    send_beat(18'd10, 18'd20, 1'b0);
    send_beat(18'd3, 18'd4, 1'b0);
    send_beat(18'd5, 18'd6, 1'b1);
    expect_result("b2b", 48'd242, 16'd3, 1'b0);

    $display("[TB] vector with gaps");
    send_beat(18'd10, 18'd20, 1'b0);
    check("gap_cep0", dsp_cep, 0);
    tick(); tick();
    send_beat(18'd3, 18'd4, 1'b0);
    check("gap_cep1", dsp_cep, 0);
    tick(); tick();
    send_beat(18'd5, 18'd6, 1'b1);
    expect_result("gap", 48'd242, 16'd3, 1'b0);

    $display("[TB] carry-out accumulation");
    send_beat(18'd10, 18'd20, 1'b0);
    send_beat(18'h3FFFF, 18'd1, 1'b1);
    expect_result("ovf", 48'd199, 16'd2, 1'b1);

    $display("[TB] signed single beat");
    send_beat(18'h3FFFE, 18'd3, 1'b1);
    expect_result("signed", 48'hFFFF_FFFF_FFFA, 16'd1, 1'b0);

    $display("[TB] backpressure");
    bus.m_ready = 1'b0;
    send_beat(18'd1, 18'd1, 1'b1);
    check("bp_ready_after1", bus.s_ready, 1);
    send_beat(18'd2, 18'd2, 1'b1);
    check("bp_ready_after2", bus.s_ready, 0);
    for (int i = 0; i < 6; i++) tick();
    check("bp_ready_full", bus.s_ready, 0);
    check("bp_valid", bus.m_valid, 1);
    check("bp_head1", bus.m_data, 1);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    check("bp_head4", bus.m_data, 4);
    check("bp_ready_freed", bus.s_ready, 1);
    send_beat(18'd3, 18'd3, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check("bp_hold4", bus.m_data, 4);
    bus.m_ready = 1'b1;
    tick();
    check("bp_head9", bus.m_data, 9);
    check("bp_len9", bus.m_len, 1);
    check("bp_valid9", bus.m_valid, 1);
    tick();
    check("bp_drained", bus.m_valid, 0);

    $display("[TB] reset mid-vector");
    send_beat(18'd1, 18'd2, 1'b0);
    send_beat(18'd3, 18'd4, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_s_ready", bus.s_ready, 1);
    check("mid_rst_m_valid", bus.m_valid, 0);
    check("mid_rst_m_data", bus.m_data, 0);
    check("mid_rst_m_len", bus.m_len, 0);
    check("mid_rst_m_ovf", bus.m_ovf, 0);
    check("mid_rst_dsp_a", dsp_a, 0);
    check("mid_rst_dsp_b", dsp_b, 0);
    check("mid_rst_opmode", dsp_opmode, 0);
    check("mid_rst_cep", dsp_cep, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mid_rst_no_result", bus.m_valid, 0);
    end
    send_beat(18'd7, 18'd8, 1'b1);
    expect_result("post_rst", 48'd56, 16'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_mac_seq.md
Name: dsp_mac_seq

Overview:
Streaming dot-product sequencer wrapped around the DSP48A1 slice. It sits upstream of the slice, driving a, b, opmode and cep, and also downstream of it, capturing p and carryout. It accepts (a,b) beat pairs over a valid/ready handshake, with s_last marking the end of a vector. It drives the slice so that P accumulates the sum of a*b over each vector, then emits one 48-bit result per vector through a 2-entry output FIFO.

Parameters:
DSP_LAT, 3, clock edges from the dsp_a/dsp_b register update to the slice P register update (A1/B1 + M + P).
LEN_W, 16, width of the per-vector beat counter.

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat ready
s_a  in  18  signed multiplicand
s_b  in  18  signed multiplier
s_last  in  1  final beat of the vector
dsp_a  out  18  to slice A; registered
dsp_b  out  18  to slice B; registered
dsp_opmode  out  8  to slice OPMODE; registered
dsp_cep  out  1  to slice CEP; registered
dsp_rstp  out  1  to slice RSTP; equals rst
dsp_p  in  48  from slice P
dsp_carryout  in  1  from slice CARRYOUT (registered, aligned with P)
m_valid  out  1  result valid
m_ready  in  1  result ready
m_data  out  48  accumulated dot product
m_len  out  LEN_W  beats in the vector; saturates at all-ones
m_ovf  out  1  OR of dsp_carryout over the vector's accumulate beats

Behaviour:
- Accept: a beat is accepted on a rising edge where s_valid && s_ready. s_ready = (credits != 0), where credits = 2 - fifo_count - lasts_in_flight.
- Input register: on accept, dsp_a <= s_a and dsp_b <= s_b. Otherwise they hold.
- FSM states are FIRST and ACC. Reset state is FIRST.
  - FIRST, accept with !s_last -> ACC.
  - ACC, accept with s_last -> FIRST.
  - Single-beat vector stays in FIRST.
- Opmode per beat (carry-in, pre-adder and post-sub bits are 0):
  - FIRST beat: 8'b0000_0001 (X=M, Z=0).
  - ACC beat: 8'b0000_1001 (X=M, Z=P).
- Delay line: a DSP_LAT+1 deep shift register carries {valid, first, last} per edge; idle edges insert valid=0. Tap k means k edges after the dsp_a update edge E0.
  - dsp_opmode is updated from tap DSP_LAT-2 at every edge.
  - dsp_cep = valid at tap DSP_LAT-1. P therefore updates only at E(DSP_LAT) of a valid beat and holds across input gaps.
- Capture: at E(DSP_LAT+1), if tap DSP_LAT has last=1, push {dsp_p, len, ovf} into the FIFO.
  - Result latency: last beat accepted at E0 → m_valid high after E4 (default parameters).
- ovf accumulator: cleared at the FIRST beat's P stage; ORs dsp_carryout at each ACC beat's P-stage capture.
- len counter: counts accepted beats; resets to 1 on a FIRST beat; saturates at all-ones.
- Output FIFO:
  - 2 entries, first in first out; m_* show the head entry.
  - Pop on m_valid && m_ready.
  - A push and a pop on the same edge are both honoured.
  - Credits guarantee a push never meets a full FIFO.
- Non-last beats are accepted only while credits != 0. P holds the partial sum while stalled.
- Reset, including mid-vector or mid-pipeline, on the next edge:
  - FSM -> FIRST; delay line cleared; FIFO emptied.
  - s_ready=1; m_valid=0; m_data=0; m_len=0; m_ovf=0.
  - dsp_a=0, dsp_b=0, dsp_opmode=0, dsp_cep=0.
  - In-flight beats are discarded; no partial result is ever emitted.
- Arithmetic is the slice's: signed 18x18 product, sign-extended to 48 bits, wrap-around on overflow.

Decomposition:
- Package dsp_mac_pkg holds:
  - OPM_FIRST = 8'h01 and OPM_ACC = 8'h09.
  - The FSM state enum.
  - A beat-tag struct {valid, first, last}.
- Sub-module mac_out_fifo: 2-entry FIFO, width 48+LEN_W+1, with count output.

Test Plan:
- Single beat a=10, b=20, last=1, m_ready=1 -> m_data=200, m_len=1, m_ovf=0, m_valid high 4 cycles after accept, for exactly 1 cycle.
- Vector (10,20), (3,4), (5,6) back-to-back -> one result: m_data=242, m_len=3.
- Same vector with 2 idle cycles between beats -> still 242 (dsp_cep=0 during the gaps); m_valid 4 cycles after the last beat.
- Signed beat a=18'h3FFFE (-2), b=3 -> m_data=48'hFFFF_FFFF_FFFA.
- Backpressure, m_ready=0, single-beat vectors 1*1, 2*2, 3*3:
  - Third beat is blocked: s_ready=0 once two results are in flight or stored.
  - Raise m_ready -> results 1, 4, 9 in order; none lost or duplicated.
- rst pulsed after 2 beats of a 3-beat vector:
  - No result emitted; all outputs zero.
  - Next single beat 7*8 -> m_data=56, m_len=1.
